i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- System-clocked I2C target (slave) with an internal byte-wide register file.
- Successor to the SCL-clocked slave: SCL and SDA are oversampled on one system clock instead of being used as clocks.
- Adds a configurable device address, parametrised depth, a register pointer with auto-increment, repeated-START handling, and a host-side read port.
- Sits between the board-level open-drain pads and on-chip logic that consumes the configuration registers.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address the block responds to.
- DEPTH, 16, number of 8-bit registers (2..256); PTR_W = max(1, clog2(DEPTH)) is a localparam.
- FILT_CYCLES, 3, number of consecutive equal samples needed to accept a new SCL/SDA level (glitch filter).
- TIMEOUT_CYCLES, 100000, SCL-low limit; used only with I2C_TIMEOUT_EN.

Ports:
- CLK_IN  in  1  system clock; must be at least 8x the SCL rate.
- RESET_IN  in  1  synchronous, active-high reset.
- SCL_IN  in  1  raw SCL pad input (asynchronous).
- SDA_IN  in  1  raw SDA pad input (asynchronous).
- SDA_OE  out  1  1 = pull SDA low; the pad ties output data to 0.
- HOST_RADDR  in  PTR_W  host read address.
- HOST_RDATA  out  8  registered register contents, 1-cycle latency.
- WR_STROBE  out  1  1-cycle pulse on each register written over I2C.
- WR_ADDR  out  PTR_W  index of the written register, valid with WR_STROBE.
- BUSY  out  1  high from an accepted START to STOP or return to IDLE.

Behaviour:
- Reset:
  - SDA_OE=0, HOST_RDATA=0, WR_STROBE=0, WR_ADDR=0, BUSY=0.
  - All registers = 0, pointer = 0, FSM = IDLE.
  - Reset applied mid-transfer releases SDA on the next CLK_IN edge.
- Input conditioning:
  - 2-flop synchroniser on each pin, then the FILT_CYCLES filter.
  - Edge detectors produce scl_rise and scl_fall.
  - START = filtered SDA falls while SCL is high; STOP = filtered SDA rises while SCL is high.
- Bit timing:
  - SDA is sampled on scl_rise.
  - SDA_OE changes only on scl_fall.
  - Bytes are MSB first; a 3-bit counter counts 0..7, and the 9th bit is ACK.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_BUS.
  - IDLE -> ADDR on START.
  - ADDR: after 8 bits, if addr[7:1]==DEV_ADDR go to ADDR_ACK (SDA_OE=1 for the 9th bit); otherwise go to WAIT_BUS with no ACK.
  - ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA. Bit 7 of the pointer's register is loaded into the shifter at the ACK-ending scl_fall, so it is driven immediately.
  - PTR: received byte < DEPTH -> pointer := byte, then PTR_ACK. Byte >= DEPTH -> NACK (SDA released), then WAIT_BUS.
  - PTR_ACK -> WDATA.
  - WDATA: after 8 bits, write reg[pointer], pulse WR_STROBE with WR_ADDR = pointer, increment pointer, then WDATA_ACK (ACK driven) -> WDATA.
  - RDATA: drive SDA_OE = ~bit, MSB first; release SDA for the 9th bit, then go to RDATA_ACK.
  - RDATA_ACK: SDA sampled low (ACK) -> pointer increments and the next byte loads -> RDATA. SDA sampled high (NACK) -> WAIT_BUS.
  - WAIT_BUS: SDA released; only START or STOP leave this state.
- Global transitions:
  - STOP in any state -> IDLE, SDA_OE=0 on the same cycle.
  - START (repeated) in any state -> ADDR; the pointer is retained.
- Pointer: wraps DEPTH-1 -> 0 for both read and write bursts.
- HOST_RDATA <= reg[HOST_RADDR] every cycle. If an I2C write hits the same index in the same cycle, the old value is returned and the new value appears one cycle later.
- BUSY = (state != IDLE).

Optional Feature:
- I2C_TIMEOUT_EN defined:
  - A counter runs while filtered SCL is low and state != IDLE.
  - When it reaches TIMEOUT_CYCLES, FSM -> IDLE and SDA_OE=0.
  - The counter clears on any SCL high.
- I2C_TIMEOUT_EN undefined: no counter; the bus can hang until STOP or reset; TIMEOUT_CYCLES is unused.

Decomposition:
- Package i2c_target_pkg holds:
  - state enum typedef;
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1;
  - RW_WRITE=1'b0, RW_READ=1'b1.
- Sub-module i2c_bus_cond holds the synchronisers, glitch filter, edge detection and START/STOP detection.
  - Outputs: scl_rise, scl_fall, sda_f, start_det, stop_det.

Test Plan:
- Write burst: START, 0xA0, ptr 0x03, data 0x11, 0x22, STOP -> ACK on all 4 bytes; reg3=0x11, reg4=0x22; two WR_STROBE pulses with WR_ADDR 3, 4; BUSY low after STOP.
- Random read: START, 0xA0, 0x03, repeated START, 0xA1, master ACK then NACK -> SDA returns 0x11 then 0x22; next read continues at pointer 5.
- Wrap: ptr 0x0F, write 0xAA, 0xBB (DEPTH=16) -> reg15=0xAA, reg0=0xBB.
- Address mismatch / bad pointer:
  - Address 0xA2 -> SDA_OE never asserted until STOP.
  - Pointer 0x20 -> NACK, then WAIT_BUS.
- Glitch and reset: a 1-cycle SDA pulse while SCL is high -> no START/STOP detected. RESET_IN asserted during the RDATA bit 4 -> SDA_OE=0 the next cycle and registers cleared.
- With I2C_TIMEOUT_EN: hold SCL low for TIMEOUT_CYCLES mid-byte -> BUSY=0 and SDA released.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the system-clocked I2C target register file.
// Contents:
//   i2c_state_t        - protocol FSM state encoding
//   I2C_ACK / I2C_NACK - SDA level of the 9th (acknowledge) bit
//   RW_WRITE / RW_READ - value of the R/W bit in the address byte
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_BUS  = 4'd9
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C pad conditioning: 2-flop synchroniser and glitch filter on SCL/SDA,
// followed by edge and START/STOP detection on the filtered levels.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   scl_raw, sda_raw    - asynchronous pad inputs
//   scl_rise, scl_fall  - 1-cycle pulses on filtered SCL edges
//   sda_f               - filtered SDA level
//   start_det, stop_det - 1-cycle pulses: SDA falls / rises while SCL high
module i2c_bus_cond #(
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_f,
  output logic start_det,
  output logic stop_det
);

  localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  // Bit 1 = SCL, bit 0 = SDA. Idle bus is high, so everything resets to 1.
  logic [1:0] meta;
  logic [1:0] sync;
  logic [1:0] filt;
  logic [1:0] filt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '1;
      sync   <= '1;
      filt_d <= '1;
    end else begin
      meta   <= {scl_raw, sda_raw};
      sync   <= meta;
      filt_d <= filt;
    end
  end

  // A new level is accepted only after FILT_CYCLES consecutive samples differ
  // from the current filtered level; any return to the old level restarts.
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        filt[g] <= 1'b1;
      end else if (sync[g] == filt[g]) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILT_CYCLES - 1)) begin
        cnt     <= '0;
        filt[g] <= sync[g];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign scl_rise  =  filt[1] & ~filt_d[1];
  assign scl_fall  = ~filt[1] &  filt_d[1];
  assign sda_f     =  filt[0];
  assign start_det =  filt[1] & filt_d[1] &  filt_d[0] & ~filt[0];
  assign stop_det  =  filt[1] & filt_d[1] & ~filt_d[0] &  filt[0];

endmodule

// File: rtl/i2c_target_regfile.sv
// System-clocked I2C target with a DEPTH x 8-bit register file.
// Protocol: START, {DEV_ADDR, R/W}, then for writes a register pointer byte
// followed by data bytes (auto-increment, wrapping at DEPTH-1); for reads the
// bytes at the current pointer are returned until the master NACKs.
// Optional feature: define I2C_TIMEOUT_EN to abort a transfer when SCL is held
// low for TIMEOUT_CYCLES system clocks.
// Ports:
//   CLK_IN, RESET_IN - system clock (>= 8x SCL), synchronous active-high reset
//   SCL_IN, SDA_IN   - raw pad inputs
//   SDA_OE           - 1 = pull SDA low
//   HOST_RADDR/RDATA - host read port, 1-cycle registered latency
//   WR_STROBE/WR_ADDR- pulse and index for every register written over I2C
//   BUSY             - transfer in progress (state != IDLE)
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h50,
  parameter int         DEPTH          = 16,
  parameter int         FILT_CYCLES    = 3,
  parameter int         TIMEOUT_CYCLES = 100000,
  localparam int        PTR_W          = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  input  logic             SCL_IN,
  input  logic             SDA_IN,
  output logic             SDA_OE,
  input  logic [PTR_W-1:0] HOST_RADDR,
  output logic [7:0]       HOST_RDATA,
  output logic             WR_STROBE,
  output logic [PTR_W-1:0] WR_ADDR,
  output logic             BUSY
);

  // Storage is rounded up to a power of two so every pointer value indexes a
  // real entry; entries at or above DEPTH are never written and stay zero.
  localparam int unsigned NREG = 1 << PTR_W;

  logic scl_rise, scl_fall, sda_f, start_det, stop_det;
  logic timeout_hit;

  i2c_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;
  logic             byte_done;
  logic             rw;
  logic             ack_rx;
  logic [7:0]       regs [NREG];

  i2c_bus_cond #(
    .FILT_CYCLES (FILT_CYCLES)
  ) u_bus_cond (
    .clk       (CLK_IN),
    .rst       (RESET_IN),
    .scl_raw   (SCL_IN),
    .sda_raw   (SDA_IN),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_f     (sda_f),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Bits are sampled on scl_rise; byte_done marks that the 8th bit has been
  // sampled so the decision and any SDA change happen on the following
  // scl_fall, keeping SDA stable while SCL is high.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      rw        <= RW_WRITE;
      ack_rx    <= I2C_NACK;
      SDA_OE    <= 1'b0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[PTR_W'(i)] <= '0;
    end else begin
      WR_STROBE <= 1'b0;
      if (stop_det || timeout_hit) begin
        state     <= ST_IDLE;
        SDA_OE    <= 1'b0;
        byte_done <= 1'b0;
      end else if (start_det) begin
        state     <= ST_ADDR;
        SDA_OE    <= 1'b0;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            shift   <= {shift[6:0], sda_f};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) byte_done <= 1'b1;
          end
          ST_RDATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) byte_done <= 1'b1;
          end
          ST_RDATA_ACK: ack_rx <= sda_f;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ADDR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              if (shift[7:1] == DEV_ADDR) begin
                rw     <= shift[0];
                SDA_OE <= 1'b1;
                state  <= ST_ADDR_ACK;
              end else begin
                SDA_OE <= 1'b0;
                state  <= ST_WAIT_BUS;
              end
            end
          end
          ST_ADDR_ACK: begin
            bit_cnt <= '0;
            if (rw == RW_READ) begin
              shift  <= regs[ptr];
              SDA_OE <= ~regs[ptr][7];
              state  <= ST_RDATA;
            end else begin
              SDA_OE <= 1'b0;
              state  <= ST_PTR;
            end
          end
          ST_PTR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              if ({1'b0, shift} < 9'(DEPTH)) begin
                ptr    <= shift[PTR_W-1:0];
                SDA_OE <= 1'b1;
                state  <= ST_PTR_ACK;
              end else begin
                SDA_OE <= 1'b0;
                state  <= ST_WAIT_BUS;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            SDA_OE  <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_WDATA;
          end
          ST_WDATA: begin
            if (byte_done) begin
              byte_done  <= 1'b0;
              regs[ptr]  <= shift;
              WR_STROBE  <= 1'b1;
              WR_ADDR    <= ptr;
              ptr        <= ptr_inc(ptr);
              SDA_OE     <= 1'b1;
              state      <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              SDA_OE    <= 1'b0;
              state     <= ST_RDATA_ACK;
            end else begin
              shift  <= {shift[6:0], 1'b0};
              SDA_OE <= ~shift[6];
            end
          end
          ST_RDATA_ACK: begin
            // The pointer advances past every transmitted byte, so a read
            // after a NACK resumes at the byte following the last one sent.
            ptr <= ptr_inc(ptr);
            if (ack_rx == I2C_ACK) begin
              shift   <= regs[ptr_inc(ptr)];
              SDA_OE  <= ~regs[ptr_inc(ptr)][7];
              bit_cnt <= '0;
              state   <= ST_RDATA;
            end else begin
              SDA_OE <= 1'b0;
              state  <= ST_WAIT_BUS;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) HOST_RDATA <= '0;
    else          HOST_RDATA <= regs[HOST_RADDR];
  end

  assign BUSY = (state != ST_IDLE);

`ifdef I2C_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            scl_lvl;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      scl_lvl <= 1'b1;
      to_cnt  <= '0;
    end else begin
      if (scl_rise)      scl_lvl <= 1'b1;
      else if (scl_fall) scl_lvl <= 1'b0;
      if (scl_lvl || (state == ST_IDLE) || timeout_hit) to_cnt <= '0;
      else                                              to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench for i2c_target_regfile: a bit-banged I2C master drives
// the DUT through an open-drain SDA model; expected ACKs, read bytes and
// register-write indices are queued when stimulus is issued and compared when
// the DUT produces them.
module tb_i2c_target_regfile;
  import i2c_target_pkg::*;

  localparam int DEPTH      = 16;
  localparam int PTR_W      = 4;
  localparam int Q          = 10;
  localparam int H          = 20;
  localparam int TB_TIMEOUT = 300;

  logic             clk = 1'b0;
  logic             rst;
  logic             scl_m;
  logic             sda_m;
  logic             sda_bus;
  logic [PTR_W-1:0] host_raddr;
  logic             SDA_OE;
  logic [7:0]       HOST_RDATA;
  logic             WR_STROBE;
  logic [PTR_W-1:0] WR_ADDR;
  logic             BUSY;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]       exp_rd_q  [$];
  logic             exp_ack_q [$];
  logic [PTR_W-1:0] exp_wr_q  [$];
  logic [PTR_W-1:0] wr_exp;
  logic             oe_watch = 1'b0;
  logic             oe_seen  = 1'b0;

  assign sda_bus = sda_m & ~SDA_OE;

  always #5 clk = ~clk;

  i2c_target_regfile #(
    .DEV_ADDR       (7'h50),
    .DEPTH          (DEPTH),
    .FILT_CYCLES    (3),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .CLK_IN     (clk),
    .RESET_IN   (rst),
    .SCL_IN     (scl_m),
    .SDA_IN     (sda_bus),
    .SDA_OE     (SDA_OE),
    .HOST_RADDR (host_raddr),
    .HOST_RDATA (HOST_RDATA),
    .WR_STROBE  (WR_STROBE),
    .WR_ADDR    (WR_ADDR),
    .BUSY       (BUSY)
  );

  always @(negedge clk) begin
    if (!rst && WR_STROBE) begin
      n_cmp++;
      if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_strobe: unexpected pulse, WR_ADDR=%0d, required no pulse", WR_ADDR);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        if (WR_ADDR !== wr_exp) begin
          n_err++;
          $display("FAIL wr_addr: got %0d, required %0d", WR_ADDR, wr_exp);
        end
      end
    end
  end

  always @(negedge clk) if (oe_watch && SDA_OE) oe_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // START from idle or repeated START from SCL low.
  task automatic bus_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(H);
    sda_m = 1'b0; clks(H);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(H);
    sda_m = 1'b1; clks(H);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    clks(Q);
    scl_m = 1'b1; clks(H);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(H / 2);
    b = sda_bus;  clks(H / 2);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic [7:0] v = d;
    logic a, e;
    exp_ack_q.push_back(exp_ack);
    for (int i = 0; i < 8; i++) begin
      write_bit(v[7]);
      v = v << 1;
    end
    read_bit(a);
    e = exp_ack_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL ack after byte %02h: got %0b, required %0b", d, a, e);
    end
  endtask

  task automatic read_byte(input logic master_ack);
    logic [7:0] v = '0;
    logic [7:0] e;
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(master_ack);
    n_cmp++;
    if (exp_rd_q.size() == 0) begin
      n_err++;
      $display("FAIL read byte: got %02h, required nothing queued", v);
    end else begin
      e = exp_rd_q.pop_front();
      if (v !== e) begin
        n_err++;
        $display("FAIL read byte: got %02h, required %02h", v, e);
      end
    end
  endtask

  task automatic host_read(input logic [PTR_W-1:0] a, output logic [7:0] d);
    host_raddr = a;
    clks(1);
    d = HOST_RDATA;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_raddr = '0;
    clks(5);
    n_cmp++;
    if ({SDA_OE, WR_STROBE, BUSY} !== 3'b000) begin
      n_err++;
      $display("FAIL reset oe/strobe/busy: got %03b, required 000", {SDA_OE, WR_STROBE, BUSY});
    end
    n_cmp++;
    if (HOST_RDATA !== 8'h00) begin
      n_err++;
      $display("FAIL reset host_rdata: got %02h, required 00", HOST_RDATA);
    end
    n_cmp++;
    if (WR_ADDR !== '0) begin
      n_err++;
      $display("FAIL reset wr_addr: got %0d, required 0", WR_ADDR);
    end
    rst = 1'b0;
    clks(10);
  endtask

  task automatic test_write_burst();
    logic [7:0] d;
    exp_wr_q.push_back(4'd3);
    exp_wr_q.push_back(4'd4);
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    write_byte(8'h03, I2C_ACK);
    write_byte(8'h11, I2C_ACK);
    write_byte(8'h22, I2C_ACK);
    n_cmp++;
    if (BUSY !== 1'b1) begin
      n_err++; $display("FAIL busy mid-write: got %0b, required 1", BUSY);
    end
    bus_stop();
    clks(10);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL busy after stop: got %0b, required 0", BUSY);
    end
    n_cmp++;
    if (exp_wr_q.size() != 0) begin
      n_err++; $display("FAIL write strobes: %0d missing, required 0", exp_wr_q.size());
    end
    host_read(4'd3, d);
    n_cmp++;
    if (d !== 8'h11) begin
      n_err++; $display("FAIL reg3: got %02h, required 11", d);
    end
    host_read(4'd4, d);
    n_cmp++;
    if (d !== 8'h22) begin
      n_err++; $display("FAIL reg4: got %02h, required 22", d);
    end
    // Seed reg5 so the resumed read below is distinguishable.
    exp_wr_q.push_back(4'd5);
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    write_byte(8'h05, I2C_ACK);
    write_byte(8'h5C, I2C_ACK);
    bus_stop();
    clks(10);
  endtask

  task automatic test_random_read();
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    write_byte(8'h03, I2C_ACK);
    bus_start();
    write_byte(8'hA1, I2C_ACK);
    exp_rd_q.push_back(8'h11);
    read_byte(I2C_ACK);
    exp_rd_q.push_back(8'h22);
    read_byte(I2C_NACK);
    bus_stop();
    clks(10);
    bus_start();
    write_byte(8'hA1, I2C_ACK);
    exp_rd_q.push_back(8'h5C);
    read_byte(I2C_NACK);
    bus_stop();
    clks(10);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    exp_wr_q.push_back(4'd15);
    exp_wr_q.push_back(4'd0);
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    write_byte(8'h0F, I2C_ACK);
    write_byte(8'hAA, I2C_ACK);
    write_byte(8'hBB, I2C_ACK);
    bus_stop();
    clks(10);
    host_read(4'd15, d);
    n_cmp++;
    if (d !== 8'hAA) begin
      n_err++; $display("FAIL reg15: got %02h, required AA", d);
    end
    host_read(4'd0, d);
    n_cmp++;
    if (d !== 8'hBB) begin
      n_err++; $display("FAIL reg0 wrap: got %02h, required BB", d);
    end
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    write_byte(8'h0F, I2C_ACK);
    bus_start();
    write_byte(8'hA1, I2C_ACK);
    exp_rd_q.push_back(8'hAA);
    read_byte(I2C_ACK);
    exp_rd_q.push_back(8'hBB);
    read_byte(I2C_NACK);
    bus_stop();
    clks(10);
  endtask

  task automatic test_addr_mismatch();
    oe_seen  = 1'b0;
    oe_watch = 1'b1;
    bus_start();
    write_byte(8'hA2, I2C_NACK);
    write_byte(8'h00, I2C_NACK);
    n_cmp++;
    if (BUSY !== 1'b1) begin
      n_err++; $display("FAIL busy in wait_bus: got %0b, required 1", BUSY);
    end
    bus_stop();
    oe_watch = 1'b0;
    clks(10);
    n_cmp++;
    if (oe_seen !== 1'b0) begin
      n_err++; $display("FAIL foreign address: SDA_OE seen %0b, required 0", oe_seen);
    end
  endtask

  task automatic test_bad_ptr();
    logic [7:0] d;
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    write_byte(8'h20, I2C_NACK);
    write_byte(8'h55, I2C_NACK);
    bus_stop();
    clks(10);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL busy after bad ptr: got %0b, required 0", BUSY);
    end
    host_read(4'd0, d);
    n_cmp++;
    if (d !== 8'hBB) begin
      n_err++; $display("FAIL reg0 after bad ptr: got %02h, required BB", d);
    end
  endtask

  task automatic test_glitch();
    sda_m = 1'b0; clks(1);
    sda_m = 1'b1; clks(20);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL start glitch: busy %0b, required 0", BUSY);
    end
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(10);
    sda_m = 1'b1; clks(1);
    sda_m = 1'b0; clks(10);
    n_cmp++;
    if (BUSY !== 1'b1) begin
      n_err++; $display("FAIL stop glitch: busy %0b, required 1", BUSY);
    end
    scl_m = 1'b0; clks(Q);
    bus_stop();
    clks(10);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL busy after real stop: got %0b, required 0", BUSY);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic b;
    bus_start();
    write_byte(8'hA0, I2C_ACK);
    write_byte(8'h04, I2C_ACK);
    bus_start();
    write_byte(8'hA1, I2C_ACK);
    // reg4 = 0x22: bits 7..5 are 0,0,1 and bit 4 is 0 (SDA pulled low).
    for (int i = 0; i < 3; i++) begin
      read_bit(b);
      n_cmp++;
      if (b !== ((i == 2) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL reg4 bit %0d: got %0b, required %0b", 7 - i, b, (i == 2));
      end
    end
    n_cmp++;
    if (SDA_OE !== 1'b1) begin
      n_err++; $display("FAIL bit4 drive: SDA_OE %0b, required 1", SDA_OE);
    end
    scl_m = 1'b1; clks(5);
    rst = 1'b1;   clks(1);
    n_cmp++;
    if ({SDA_OE, BUSY} !== 2'b00) begin
      n_err++; $display("FAIL reset mid-read oe/busy: got %02b, required 00", {SDA_OE, BUSY});
    end
    sda_m = 1'b1; clks(3);
    rst = 1'b0;   clks(10);
    host_read(4'd4, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_err++; $display("FAIL reg4 after reset: got %02h, required 00", d);
    end
    host_read(4'd15, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_err++; $display("FAIL reg15 after reset: got %02h, required 00", d);
    end
  endtask

`ifdef I2C_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] v = 8'hA0;
    bus_start();
    for (int i = 0; i < 8; i++) begin
      write_bit(v[7]);
      v = v << 1;
    end
    clks(10);
    n_cmp++;
    if (SDA_OE !== 1'b1) begin
      n_err++; $display("FAIL timeout setup ack: SDA_OE %0b, required 1", SDA_OE);
    end
    clks(TB_TIMEOUT + 50);
    n_cmp++;
    if ({BUSY, SDA_OE} !== 2'b00) begin
      n_err++; $display("FAIL timeout busy/oe: got %02b, required 00", {BUSY, SDA_OE});
    end
    bus_stop();
    clks(10);
  endtask
`endif

  initial begin
    test_reset();
    test_write_burst();
    test_random_read();
    test_wrap();
    test_addr_mismatch();
    test_bad_ptr();
    test_glitch();
    test_reset_mid();
`ifdef I2C_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d writes / %0d reads left, required 0", exp_wr_q.size(), exp_rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
